// File: rtl/hls_test_pkg.sv
// Shared types for hls_test_sequencer: FSM state encoding, counter width and
// the packed-channel slice helper.
package hls_test_pkg;

  localparam int CNT_W     = 32;
  localparam int SLICE_MAX = 64;
  localparam int VEC_MAX   = 1024;

  localparam logic [2:0] CHECK_ENC = 3'd5;
  localparam logic [2:0] DONE_ENC  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_WAIT  = 3'd1,
    S_RST_PULSE = 3'd2,
    S_REQ_WAIT  = 3'd3,
    S_RUN       = 3'd4,
    S_CHECK     = CHECK_ENC,
    S_DONE      = DONE_ENC
  } state_t;

  // Extract element idx of width w from a zero-extended packed channel vector.
  function automatic logic [SLICE_MAX-1:0] get_slice(input logic [VEC_MAX-1:0] vec,
                                                     input int unsigned idx,
                                                     input int unsigned w);
    logic [VEC_MAX-1:0]   shifted;
    logic [SLICE_MAX-1:0] mask;
    shifted = vec >> (idx * w);
    mask    = (w >= 32'd64) ? {SLICE_MAX{1'b1}} : ((64'd1 << w) - 64'd1);
    return shifted[SLICE_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/hls_test_channel.sv
// One method channel of hls_test_sequencer: req level, completion flag,
// captured return value and comparison against the golden value.
module hls_test_channel #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             fire,
  input  logic             guard_done,
  input  logic             busy,
  input  logic [RET_W-1:0] ret,
  input  logic [RET_W-1:0] exp,
  input  logic             abort,
  output logic             req,
  output logic             complete,
  output logic             mismatch
);

  logic [RET_W-1:0] capture_r;

  // req/complete/capture state; abort keeps what was already captured
  always_ff @(posedge clk) begin
    if (!reset) begin
      req       <= 1'b0;
      complete  <= 1'b0;
      capture_r <= {RET_W{1'b0}};
    end else if (clear) begin
      req       <= 1'b0;
      complete  <= 1'b0;
      capture_r <= {RET_W{1'b0}};
    end else if (abort) begin
      req <= 1'b0;
    end else if (fire) begin
      req      <= 1'b1;
      complete <= 1'b0;
    end else if (req && guard_done && !busy) begin
      capture_r <= ret;
      complete  <= 1'b1;
      req       <= 1'b0;
    end
  end

  assign mismatch = (capture_r != exp);

endmodule

// File: rtl/hls_test_sequencer.sv
// Self-test sequencer for generated method blocks: DUT reset pulse, parallel
// req/busy handshake, return capture and verdict. Optional HLS_TEST_TIMEOUT_EN.
module hls_test_sequencer
  import hls_test_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int RET_W      = 32,
  parameter int RST_START  = 3,
  parameter int RST_LEN    = 6,
  parameter int REQ_DELAY  = 100,
  parameter int BUSY_GUARD = 5,
  parameter int TIMEOUT    = 10000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      dut_reset,
  output logic [CHANNELS-1:0]       dut_req,
  input  logic [CHANNELS-1:0]       dut_busy,
  input  logic [CHANNELS*RET_W-1:0] dut_return,
  input  logic [CHANNELS*RET_W-1:0] expected,
  output logic                      done,
  output logic                      pass,
  output logic [CHANNELS-1:0]       fail_vec,
  output logic                      timed_out,
  output logic [CNT_W-1:0]          cycles
);

  localparam logic [CNT_W-1:0] RST_ON  = CNT_W'(RST_START - 1);
  localparam logic [CNT_W-1:0] RST_OFF = CNT_W'(RST_START + RST_LEN - 1);
  localparam logic [CNT_W-1:0] REQ_ON  = CNT_W'(REQ_DELAY - 1);
  localparam logic [CNT_W-1:0] GUARD   = CNT_W'(BUSY_GUARD);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     guard_cnt;
  logic [CHANNELS-1:0]  complete;
  logic [CHANNELS-1:0]  mismatch;
  logic [CHANNELS-1:0]  fail_now;
  logic [VEC_MAX-1:0]   ret_ext;
  logic [VEC_MAX-1:0]   exp_ext;
  logic                 start_ok;
  logic                 fire;
  logic                 guard_done;
  logic                 timeout_hit;

  assign ret_ext    = VEC_MAX'(dut_return);
  assign exp_ext    = VEC_MAX'(expected);
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign fire       = (state == S_REQ_WAIT) && (cnt == REQ_ON) && !timeout_hit;
  assign guard_done = (state == S_RUN) && (guard_cnt >= GUARD);
  assign fail_now   = mismatch | ~complete;

`ifdef HLS_TEST_TIMEOUT_EN
  assign timeout_hit = (state != S_IDLE) && (state != S_DONE) && (state != S_CHECK) &&
                       (cnt == TO_CNT);

  // Sticky timeout flag, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (!reset) begin
      timed_out <= 1'b0;
    end else if (start_ok) begin
      timed_out <= 1'b0;
    end else if (timeout_hit) begin
      timed_out <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign timed_out      = 1'b0;
  assign unused_timeout = ^TO_CNT;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [RET_W-1:0] ret_i;
    logic [RET_W-1:0] exp_i;
    assign ret_i = RET_W'(get_slice(ret_ext, i, RET_W));
    assign exp_i = RET_W'(get_slice(exp_ext, i, RET_W));

    hls_test_channel #(.RET_W(RET_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_ok),
      .fire       (fire),
      .guard_done (guard_done),
      .busy       (dut_busy[i]),
      .ret        (ret_i),
      .exp        (exp_i),
      .abort      (timeout_hit),
      .req        (dut_req[i]),
      .complete   (complete[i]),
      .mismatch   (mismatch[i])
    );
  end

  // Sequencer FSM, saturating run counter, DUT reset pulse and verdict registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= {CNT_W{1'b0}};
      guard_cnt <= {CNT_W{1'b0}};
      dut_reset <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_vec  <= {CHANNELS{1'b0}};
      cycles    <= {CNT_W{1'b0}};
    end else begin
      if ((state != S_IDLE) && (state != S_DONE) && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 32'd1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt      <= {CNT_W{1'b0}};
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= {CHANNELS{1'b0}};
            state    <= S_RST_WAIT;
          end
        end
        S_RST_WAIT: begin
          if (cnt == RST_ON) begin
            dut_reset <= 1'b1;
            state     <= S_RST_PULSE;
          end
        end
        S_RST_PULSE: begin
          if (cnt == RST_OFF) begin
            dut_reset <= 1'b0;
            state     <= S_REQ_WAIT;
          end
        end
        S_REQ_WAIT: begin
          if (cnt == REQ_ON) begin
            guard_cnt <= {CNT_W{1'b0}};
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (guard_cnt < GUARD) begin
            guard_cnt <= guard_cnt + 32'd1;
          end
          if (&complete) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          fail_vec <= fail_now;
          pass     <= ~|fail_now & ~timed_out;
          cycles   <= cnt;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (timeout_hit) begin
        dut_reset <= 1'b0;
        state     <= S_CHECK;
      end
    end
  end

endmodule

// File: tb/tb_hls_test_sequencer.sv
// Directed self-checking bench for hls_test_sequencer (CHANNELS=2), with a
// behavioural busy model per channel; timeout scenario under HLS_TEST_TIMEOUT_EN.
module tb_hls_test_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dut_reset;
  logic [1:0]  dut_req;
  logic [1:0]  dut_busy;
  logic [63:0] dut_return;
  logic [63:0] expected;
  logic        done;
  logic        pass;
  logic [1:0]  fail_vec;
  logic        timed_out;
  logic [31:0] cycles;

  int compared   = 0;
  int mismatched = 0;
  int rise [2];
  int fall [2];
  int age  [2];

  hls_test_sequencer #(
    .CHANNELS(2), .RET_W(32), .RST_START(3), .RST_LEN(6),
    .REQ_DELAY(100), .BUSY_GUARD(5), .TIMEOUT(300)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dut_reset(dut_reset),
    .dut_req(dut_req), .dut_busy(dut_busy), .dut_return(dut_return),
    .expected(expected), .done(done), .pass(pass), .fail_vec(fail_vec),
    .timed_out(timed_out), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Method model: age counts cycles since req rose, busy follows the profile
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) age[i] <= dut_req[i] ? age[i] + 1 : 0;
  end

  always_comb begin
    dut_busy = 2'b00;
    for (int i = 0; i < 2; i++)
      dut_busy[i] = dut_req[i] && (age[i] >= rise[i]) && (age[i] < fall[i]);
  end

  task automatic set_profile(input int r0, input int f0, input int r1, input int f1,
                             input logic [31:0] ret0, input logic [31:0] ret1,
                             input logic [31:0] exp0, input logic [31:0] exp1);
    rise[0] = r0; fall[0] = f0; rise[1] = r1; fall[1] = f1;
    dut_return = {ret1, ret0};
    expected   = {exp1, exp0};
  endtask

  // Pulse start, then step edge by edge until done (bounded); k counts edges after start
  task automatic run_seq(input int restart_k, output int done_k, output int rst_first,
                         output int rst_last, output int req_first);
    int k = 0;
    rst_first = -1; rst_last = -1; req_first = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done !== 1'b1 && k < 1000) begin
      @(posedge clk); #1;
      k++;
      start = (k == restart_k);
      if (dut_reset === 1'b1) begin
        if (rst_first < 0) rst_first = k;
        rst_last = k;
      end
      if (dut_req !== 2'b00 && req_first < 0) req_first = k;
    end
    start  = 1'b0;
    done_k = (done === 1'b1) ? k : -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if ({done, pass, timed_out} !== 3'b000) begin mismatched++;
      $display("FAIL reset_flags: got %b expected 000", {done, pass, timed_out}); end
    compared++; if ({dut_reset, dut_req, fail_vec} !== 5'b0) begin mismatched++;
      $display("FAIL reset_vecs: got %b expected 00000", {dut_reset, dut_req, fail_vec}); end
    compared++; if (cycles !== 32'd0) begin mismatched++;
      $display("FAIL reset_cycles: got %0d expected 0", cycles); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int dk, rf, rl, qf;
    set_profile(1, 20, 1, 20, 32'd200, 32'd100, 32'd200, 32'd100);
    run_seq(-1, dk, rf, rl, qf);
    compared++; if (rf !== 3 || rl !== 8) begin mismatched++;
      $display("FAIL nom_rst_window: got %0d..%0d expected 3..8", rf, rl); end
    compared++; if (qf !== 100) begin mismatched++;
      $display("FAIL nom_req_latency: got %0d expected 100", qf); end
    compared++; if (dk !== 123) begin mismatched++;
      $display("FAIL nom_done_edge: got %0d expected 123", dk); end
    compared++; if (cycles !== 32'd122) begin mismatched++;
      $display("FAIL nom_cycles: got %0d expected 122", cycles); end
    compared++; if ({pass, fail_vec, timed_out, dut_req} !== 6'b100000) begin mismatched++;
      $display("FAIL nom_verdict: got %b expected 100000", {pass, fail_vec, timed_out, dut_req}); end
  endtask

  task automatic test_mismatch();
    int dk, rf, rl, qf;
    set_profile(1, 20, 1, 30, 32'd200, 32'd99, 32'd200, 32'd100);
    run_seq(-1, dk, rf, rl, qf);
    compared++; if (cycles !== 32'd132) begin mismatched++;
      $display("FAIL mis_cycles: got %0d expected 132", cycles); end
    compared++; if ({done, pass, fail_vec, timed_out} !== 5'b10100) begin mismatched++;
      $display("FAIL mis_verdict: got %b expected 10100", {done, pass, fail_vec, timed_out}); end
  endtask

  task automatic test_guard();
    int dk, rf, rl, qf;
    set_profile(3, 40, 3, 40, 32'd7, 32'd8, 32'd7, 32'd8);
    run_seq(-1, dk, rf, rl, qf);
    compared++; if (cycles !== 32'd142) begin mismatched++;
      $display("FAIL guard_cycles: got %0d expected 142", cycles); end
    compared++; if ({done, pass, fail_vec} !== 4'b1100) begin mismatched++;
      $display("FAIL guard_verdict: got %b expected 1100", {done, pass, fail_vec}); end
  endtask

  task automatic test_start_ignored();
    int dk, rf, rl, qf;
    set_profile(1, 20, 1, 20, 32'hdead_beef, 32'h1234_5678, 32'hdead_beef, 32'h1234_5678);
    run_seq(110, dk, rf, rl, qf);
    compared++; if (dk !== 123 || cycles !== 32'd122) begin mismatched++;
      $display("FAIL ign_cycles: got edge %0d cycles %0d expected 123/122", dk, cycles); end
    compared++; if ({pass, fail_vec} !== 3'b100) begin mismatched++;
      $display("FAIL ign_verdict: got %b expected 100", {pass, fail_vec}); end
  endtask

  task automatic test_abort();
    int dk, rf, rl, qf;
    set_profile(1, 100000, 1, 100000, 32'd200, 32'd100, 32'd200, 32'd100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    compared++; if (dut_req !== 2'b11) begin mismatched++;
      $display("FAIL abort_pre_req: got %b expected 11", dut_req); end
    reset = 1'b0;
    @(posedge clk); #1;
    compared++; if ({dut_req, done, dut_reset} !== 4'b0000) begin mismatched++;
      $display("FAIL abort_post: got %b expected 0000", {dut_req, done, dut_reset}); end
    reset = 1'b1;
    @(posedge clk); #1;
    set_profile(1, 20, 1, 20, 32'd200, 32'd100, 32'd200, 32'd100);
    run_seq(-1, dk, rf, rl, qf);
    compared++; if (rf !== 3 || rl !== 8 || qf !== 100 || cycles !== 32'd122) begin mismatched++;
      $display("FAIL abort_replay: got rst %0d..%0d req %0d cycles %0d expected 3..8/100/122",
               rf, rl, qf, cycles); end
    compared++; if ({done, pass, fail_vec} !== 4'b1100) begin mismatched++;
      $display("FAIL abort_replay_verdict: got %b expected 1100", {done, pass, fail_vec}); end
  endtask

`ifdef HLS_TEST_TIMEOUT_EN
  task automatic test_timeout();
    int dk, rf, rl, qf;
    set_profile(1, 100000, 1, 20, 32'd200, 32'd100, 32'd200, 32'd100);
    run_seq(-1, dk, rf, rl, qf);
    compared++; if (dk !== 302 || cycles !== 32'd301) begin mismatched++;
      $display("FAIL to_cycles: got edge %0d cycles %0d expected 302/301", dk, cycles); end
    compared++; if ({timed_out, pass, fail_vec, dut_req} !== 6'b100100) begin mismatched++;
      $display("FAIL to_verdict: got %b expected 100100", {timed_out, pass, fail_vec, dut_req}); end
  endtask
`endif

  initial begin
    set_profile(1, 20, 1, 20, 32'd0, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_nominal();
    test_mismatch();
    test_guard();
    test_start_ignored();
    test_abort();
`ifdef HLS_TEST_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
